// File: rtl/sbox_sweep_pkg.sv
// sbox_sweep_pkg: shared widths, FSM states and counter types for the S-box sweep checker
package sbox_sweep_pkg;
  localparam int N = 6;
  localparam int SIZE = 1 << N;
  typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;
  typedef logic [N-1:0] cnt_t;
  typedef logic [N:0] count_t;
endpackage

// File: rtl/seen_bitmap.sv
// seen_bitmap: one flag per S-box output value, cleared at sweep start and set as values appear
module seen_bitmap
  import sbox_sweep_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic set,
  input  cnt_t idx,
  output logic hit
);
  logic [SIZE-1:0] bits;
  always_ff @(posedge clk) begin
    if (rst || clr) bits <= '0;
    else if (set) bits[idx] <= 1'b1;
  end
  assign hit = bits[idx];
endmodule

// File: rtl/sbox6_sweep_checker.sv
// sbox6_sweep_checker: sweeps x=0..63 into an external S-box and reports bijectivity, collisions, fixed points and XOR sum
module sbox6_sweep_checker #(
  parameter int N = 6,
  parameter int SIZE = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] sbox_x,
  input  logic [N-1:0] sbox_y,
  output logic         is_perm,
  output logic [N:0]   dup_count,
  output logic         first_dup_valid,
  output logic [N-1:0] first_dup_x,
  output logic [N:0]   fixed_count,
  output logic [N-1:0] xor_sum
);
  import sbox_sweep_pkg::*;
  state_t state;
  cnt_t cnt;
  logic hit, accept, last;
  assign accept = state == IDLE && start;
  assign last = cnt == cnt_t'(SIZE - 1);
  assign busy = state != IDLE;
  assign done = state == DONE;
  assign sbox_x = state == SWEEP ? cnt : '0;
  seen_bitmap u_seen (
    .clk(clk),
    .rst(rst),
    .clr(accept),
    .set(state == SWEEP),
    .idx(sbox_y),
    .hit(hit)
  );
  always_ff @(posedge clk) begin
    if (rst || accept) begin
      state <= rst ? IDLE : SWEEP;
      cnt <= '0;
      dup_count <= '0;
      fixed_count <= '0;
      xor_sum <= '0;
      first_dup_valid <= 1'b0;
      first_dup_x <= '0;
      is_perm <= 1'b0;
    end else begin
      case (state)
        SWEEP: begin
          xor_sum <= xor_sum ^ sbox_y;
          fixed_count <= fixed_count + count_t'(sbox_y == cnt);
          dup_count <= dup_count + count_t'(hit);
          if (hit && !first_dup_valid) begin
            first_dup_valid <= 1'b1;
            first_dup_x <= cnt;
          end
          cnt <= cnt + 1'b1;
          // final dup_count includes this cycle's hit, so fold it in here
          if (last) begin
            state <= DONE;
            is_perm <= dup_count == '0 && !hit;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sbox6_sweep_checker.sv
// tb_sbox6_sweep_checker: scoreboard bench driving reference S-boxes into the sweep checker
module tb_sbox6_sweep_checker;
  logic clk = 0, rst = 1, start = 0;
  logic busy, done, is_perm, first_dup_valid;
  logic [5:0] sbox_x, sbox_y, first_dup_x, xor_sum;
  logic [6:0] dup_count, fixed_count;
  int mode = 0, cyc = 0, n_vec = 0, n_err = 0, k = 0, t = 0;
  typedef struct {int ks; int perm; int dup; int fdv; int fdx; int fixed; int xs;} exp_t;
  exp_t q[$];
  exp_t last_exp;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  sbox6_sweep_checker dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .sbox_x(sbox_x), .sbox_y(sbox_y), .is_perm(is_perm), .dup_count(dup_count),
    .first_dup_valid(first_dup_valid), .first_dup_x(first_dup_x),
    .fixed_count(fixed_count), .xor_sum(xor_sum)
  );
  // GF(2^6) with modulus x^6 + x + 1
  function automatic logic [5:0] gmul(input logic [5:0] a, input logic [5:0] b);
    logic [5:0] r = 0;
    logic [5:0] s = a;
    for (int i = 0; i < 6; i++) begin
      if (b[i]) r ^= s;
      s = s[5] ? ((s << 1) ^ 6'h03) : (s << 1);
    end
    return r;
  endfunction
  function automatic logic [5:0] gpow41(input logic [5:0] x);
    logic [5:0] r = 6'd1;
    logic [5:0] b = x;
    logic [5:0] e = 6'd41;
    for (int i = 0; i < 6; i++) begin
      if (e[i]) r = gmul(r, b);
      b = gmul(b, b);
    end
    return r;
  endfunction
  function automatic logic [5:0] sbox(input int m, input logic [5:0] x);
    return m == 0 ? x : m == 1 ? 6'd5 : m == 2 ? gpow41(x) : x ^ 6'h01;
  endfunction
  always_comb sbox_y = sbox(mode, sbox_x);
  function automatic exp_t model(input int m, input int ks);
    exp_t e;
    logic [63:0] seen = 0;
    logic [5:0] y;
    e = '{ks, 0, 0, 0, 0, 0, 0};
    for (int x = 0; x < 64; x++) begin
      y = sbox(m, 6'(x));
      e.xs ^= int'(y);
      if (int'(y) == x) e.fixed++;
      if (seen[y]) begin
        e.dup++;
        if (e.fdv == 0) begin
          e.fdv = 1;
          e.fdx = x;
        end
      end
      seen[y] = 1'b1;
    end
    e.perm = e.dup == 0 ? 1 : 0;
    return e;
  endfunction
  task automatic chk(input string tag, input int got, input int want);
    n_vec++;
    if (got != want) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask
  task automatic chk_results(input string p, input exp_t e);
    chk({p, "_is_perm"}, is_perm, e.perm);
    chk({p, "_dup_count"}, dup_count, e.dup);
    chk({p, "_first_dup_valid"}, first_dup_valid, e.fdv);
    chk({p, "_first_dup_x"}, first_dup_x, e.fdx);
    chk({p, "_fixed_count"}, fixed_count, e.fixed);
    chk({p, "_xor_sum"}, xor_sum, e.xs);
  endtask
  task automatic chk_idle_zero(input string p);
    chk({p, "_busy"}, busy, 0);
    chk({p, "_done"}, done, 0);
    chk({p, "_sbox_x"}, sbox_x, 0);
    chk_results(p, '{0, 0, 0, 0, 0, 0, 0});
  endtask
  always @(negedge clk) begin
    if (!rst && done) begin
      if (q.size() == 0) chk("spurious_done", 1, 0);
      else begin
        last_exp = q.pop_front();
        chk("done_cycle", cyc, last_exp.ks + 64);
        chk("busy_at_done", busy, 1);
        chk_results("done", last_exp);
      end
    end else if (!rst && busy && q.size() > 0) chk("sbox_x", sbox_x, cyc - q[0].ks);
  end
  // called at a falling edge; start is sampled by the next rising edge
  task automatic launch(input int m);
    int w = 0;
    while (busy && w < 200) begin
      @(negedge clk);
      w++;
    end
    mode = m;
    q.push_back(model(m, cyc + 1));
    start = 1;
    @(negedge clk);
    start = 0;
  endtask
  task automatic drain();
    int w = 0;
    while (q.size() > 0 && w < 200) begin
      @(negedge clk);
      #1;
      w++;
    end
    if (q.size() > 0) begin
      chk("drain_timeout", q.size(), 0);
      q.delete();
    end
  endtask
  initial begin
    repeat (3) @(negedge clk);
    chk_idle_zero("reset");
    rst = 0;
    @(negedge clk);
    launch(0);
    drain();
    repeat (5) @(negedge clk);
    chk("idle_busy", busy, 0);
    chk_results("hold_identity", last_exp);
    launch(1);
    drain();
    launch(2);
    drain();
    launch(3);
    k = cyc;
    while (cyc < k + 9) @(negedge clk);
    start = 1;
    @(negedge clk);
    start = 0;
    while (cyc < k + 64) @(negedge clk);
    start = 1;
    @(negedge clk);
    start = 0;
    repeat (80) @(negedge clk);
    chk("affine_queue", q.size(), 0);
    chk_results("hold_affine", last_exp);
    launch(0);
    t = 0;
    while (sbox_x != 6'd30 && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("reach_x30", sbox_x, 30);
    q.delete();
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk_idle_zero("abort");
    repeat (70) @(negedge clk);
    chk("abort_busy", busy, 0);
    launch(0);
    drain();
    launch(0);
    drain();
    launch(1);
    drain();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
